// File: rtl/mlp_noc_pkg.sv
// Shared NoC definitions: operation codes, TUSER field layout and injector FSM states.
package mlp_noc_pkg;

  typedef enum logic [1:0] {
    OP_WEIGHT = 2'd0,
    OP_INPUT  = 2'd1,
    OP_INST   = 2'd2,
    OP_RESULT = 2'd3
  } axis_op_e;

  localparam int OP_LSB     = 0;
  localparam int OP_W       = 2;
  localparam int RFADDR_LSB = 2;
  localparam int UOP_W      = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } inj_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage valid/ready register slice; holds its payload while the sink stalls.
module axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/mlp_axis_injector.sv
// Builds AXI-Stream packets for the MVM NoC from host commands and a raw payload stream.
module mlp_axis_injector
  import mlp_noc_pkg::*;
#(
  parameter int DATAW   = 32,
  parameter int USERW   = 75,
  parameter int DESTW   = 12,
  parameter int IDW     = 4,
  parameter int RFADDRW = 9,
  parameter int LENW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DESTW-1:0]   cmd_dest,
  input  logic [IDW-1:0]     cmd_id,
  input  logic [1:0]         cmd_op,
  input  logic [RFADDRW-1:0] cmd_rfaddr,
  input  logic [LENW-1:0]    cmd_len,
  input  logic               s_data_valid,
  output logic               s_data_ready,
  input  logic [DATAW-1:0]   s_data,
  output logic               axis_tx_tvalid,
  input  logic               axis_tx_tready,
  output logic [DATAW-1:0]   axis_tx_tdata,
  output logic               axis_tx_tlast,
  output logic [IDW-1:0]     axis_tx_tid,
  output logic [USERW-1:0]   axis_tx_tuser,
  output logic [DESTW-1:0]   axis_tx_tdest,
  output logic               done,
  output logic [15:0]        pkt_count
);

  localparam int PAYW = DATAW + 1 + IDW + USERW + DESTW;

  inj_state_e         state;
  logic [DESTW-1:0]   dest_q;
  logic [IDW-1:0]     id_q;
  axis_op_e           op_q;
  logic [RFADDRW-1:0] rf_addr;
  logic [LENW-1:0]    beats_left;

  logic               cmd_fire;
  logic               in_valid;
  logic               in_ready;
  logic               data_fire;
  logic               last_fire;
  logic [USERW-1:0]   beat_user;
  logic [PAYW-1:0]    in_pay;
  logic [PAYW-1:0]    out_pay;

  assign cmd_fire     = cmd_valid & cmd_ready;
  assign in_valid     = s_data_valid & (state == ST_SEND);
  assign s_data_ready = in_ready & (state == ST_SEND);
  assign data_fire    = in_valid & in_ready;
  assign last_fire    = (state == ST_DRAIN) & axis_tx_tvalid & axis_tx_tready & axis_tx_tlast;

  always_comb begin
    beat_user = '0;
    beat_user[OP_LSB +: OP_W]        = op_q;
    beat_user[RFADDR_LSB +: RFADDRW] = rf_addr;
  end

  assign in_pay = {s_data, (beats_left == LENW'(1)), id_q, beat_user, dest_q};

  // cmd_ready reopens one cycle after returning to IDLE, so a new command lands after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b0;
      done       <= 1'b0;
      pkt_count  <= '0;
      dest_q     <= '0;
      id_q       <= '0;
      op_q       <= OP_WEIGHT;
      rf_addr    <= '0;
      beats_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= ~cmd_fire;
          if (cmd_fire) begin
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              state      <= ST_SEND;
              dest_q     <= cmd_dest;
              id_q       <= cmd_id;
              op_q       <= axis_op_e'(cmd_op);
              rf_addr    <= cmd_rfaddr;
              beats_left <= cmd_len;
            end
          end
        end
        ST_SEND: begin
          cmd_ready <= 1'b0;
          if (data_fire) begin
            rf_addr    <= rf_addr + 1'b1;
            beats_left <= beats_left - 1'b1;
            if (beats_left == LENW'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          cmd_ready <= 1'b0;
          if (last_fire) begin
            state     <= ST_IDLE;
            done      <= 1'b1;
            pkt_count <= pkt_count + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  axis_out_reg #(.W(PAYW)) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pay),
    .out_valid(axis_tx_tvalid),
    .out_ready(axis_tx_tready),
    .out_data (out_pay)
  );

  assign {axis_tx_tdata, axis_tx_tlast, axis_tx_tid, axis_tx_tuser, axis_tx_tdest} = out_pay;

endmodule

// File: tb/tb_mlp_axis_injector.sv
// Scoreboard bench for mlp_axis_injector: directed commands, expected beats queued at data handshake.
module tb_mlp_axis_injector;

  localparam int DATAW   = 32;
  localparam int USERW   = 75;
  localparam int DESTW   = 12;
  localparam int IDW     = 4;
  localparam int RFADDRW = 9;
  localparam int LENW    = 8;

  typedef struct {
    logic [DATAW-1:0] data;
    logic             last;
    logic [IDW-1:0]   id;
    logic [USERW-1:0] user;
    logic [DESTW-1:0] dest;
  } beat_t;

  logic               clk;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [DESTW-1:0]   cmd_dest;
  logic [IDW-1:0]     cmd_id;
  logic [1:0]         cmd_op;
  logic [RFADDRW-1:0] cmd_rfaddr;
  logic [LENW-1:0]    cmd_len;
  logic               s_data_valid;
  logic               s_data_ready;
  logic [DATAW-1:0]   s_data;
  logic               tvalid;
  logic               tready;
  logic [DATAW-1:0]   tdata;
  logic               tlast;
  logic [IDW-1:0]     tid;
  logic [USERW-1:0]   tuser;
  logic [DESTW-1:0]   tdest;
  logic               done;
  logic [15:0]        pkt_count;

  mlp_axis_injector dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dest      (cmd_dest),
    .cmd_id        (cmd_id),
    .cmd_op        (cmd_op),
    .cmd_rfaddr    (cmd_rfaddr),
    .cmd_len       (cmd_len),
    .s_data_valid  (s_data_valid),
    .s_data_ready  (s_data_ready),
    .s_data        (s_data),
    .axis_tx_tvalid(tvalid),
    .axis_tx_tready(tready),
    .axis_tx_tdata (tdata),
    .axis_tx_tlast (tlast),
    .axis_tx_tid   (tid),
    .axis_tx_tuser (tuser),
    .axis_tx_tdest (tdest),
    .done          (done),
    .pkt_count     (pkt_count)
  );

  int    checks   = 0;
  int    errors   = 0;
  int    cyc      = 0;
  int    done_cnt = 0;
  int    beat_cnt = 0;
  int    stamps[$];
  beat_t exp_q[$];
  logic  toggle_en = 1'b0;

  int    cur_dest, cur_id, cur_op, cur_rf, cur_len, cur_idx;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Sink: tready either held high or stepping through 1,0,0,1.
  initial begin
    logic [3:0] pat;
    int ti;
    pat = 4'b1001;
    ti = 0;
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) begin
        tready = pat[ti];
        ti = (ti + 1) % 4;
      end else begin
        tready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each output handshake and watches stall behaviour.
  initial begin
    logic        prev_stall;
    logic [123:0] prev_pay;
    beat_t       e;
    prev_stall = 1'b0;
    prev_pay   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (prev_stall) begin
          chk("stall_tvalid_held", 128'(tvalid), 128'(1));
          chk("stall_fields_stable", 128'({tdata, tlast, tid, tuser, tdest}), 128'(prev_pay));
        end
        if (tvalid && !tready) chk("s_data_ready_low_on_stall", 128'(s_data_ready), 128'(0));
        if (tvalid && tready) begin
          beat_cnt++;
          stamps.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected actual=%0h required=none", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tdata", 128'(tdata), 128'(e.data));
            chk("beat_tlast", 128'(tlast), 128'(e.last));
            chk("beat_tid",   128'(tid),   128'(e.id));
            chk("beat_tuser", 128'(tuser), 128'(e.user));
            chk("beat_tdest", 128'(tdest), 128'(e.dest));
          end
        end
        prev_stall = tvalid && !tready;
        prev_pay   = {tdata, tlast, tid, tuser, tdest};
      end
    end
  end

  task automatic send_cmd(input int dest, input int id, input int op, input int rf, input int len);
    int n;
    cur_dest = dest; cur_id = id; cur_op = op; cur_rf = rf; cur_len = len; cur_idx = 0;
    cmd_valid  = 1'b1;
    cmd_dest   = DESTW'(dest);
    cmd_id     = IDW'(id);
    cmd_op     = 2'(op);
    cmd_rfaddr = RFADDRW'(rf);
    cmd_len    = LENW'(len);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    if (!cmd_ready) chk("cmd_ready_timeout", 128'(cmd_ready), 128'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_words(input int count, input int base);
    int    n;
    beat_t b;
    for (int i = 0; i < count; i++) begin
      s_data_valid = 1'b1;
      s_data       = DATAW'(base + i);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s_data_ready && n < 50);
      if (!s_data_ready) begin
        chk("s_data_ready_timeout", 128'(s_data_ready), 128'(1));
      end else begin
        b.data = DATAW'(base + i);
        b.last = (cur_idx == cur_len - 1);
        b.id   = IDW'(cur_id);
        b.dest = DESTW'(cur_dest);
        b.user = '0;
        b.user[1:0]  = 2'(cur_op);
        b.user[10:2] = 9'((cur_rf + cur_idx) % 512);
        exp_q.push_back(b);
        cur_idx++;
      end
      @(posedge clk);
      #1;
    end
    s_data_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", 128'(done_cnt), 128'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tvalid"},    128'(tvalid),       128'(0));
    chk({tag, "_tdata"},     128'(tdata),        128'(0));
    chk({tag, "_tlast"},     128'(tlast),        128'(0));
    chk({tag, "_tid"},       128'(tid),          128'(0));
    chk({tag, "_tuser"},     128'(tuser),        128'(0));
    chk({tag, "_tdest"},     128'(tdest),        128'(0));
    chk({tag, "_done"},      128'(done),         128'(0));
    chk({tag, "_pkt_count"}, 128'(pkt_count),    128'(0));
    chk({tag, "_cmd_ready"}, 128'(cmd_ready),    128'(0));
    chk({tag, "_s_ready"},   128'(s_data_ready), 128'(0));
  endtask

  initial begin
    int bc;
    int d0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_dest = '0; cmd_id = '0; cmd_op = '0; cmd_rfaddr = '0; cmd_len = '0;
    s_data_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Basic 4-beat packet, tready high.
    send_cmd(12'h003, 2, 1, 5, 4);
    stamps.delete();
    send_words(4, 32'hA0);
    wait_done(1);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_beats", 128'(stamps.size()), 128'(4));
    if (stamps.size() == 4) chk("t1_back_to_back", 128'(stamps[3] - stamps[0]), 128'(3));
    chk("t1_done_once", 128'(done_cnt), 128'(1));
    chk("t1_pkt_count", 128'(pkt_count), 128'(1));

    // Same command with a stalling sink.
    toggle_en = 1'b1;
    send_cmd(12'h003, 2, 1, 5, 4);
    send_words(4, 32'hB0);
    wait_done(2);
    toggle_en = 1'b0;
    chk("t2_pkt_count", 128'(pkt_count), 128'(2));

    // RF address wraps 510, 511, 0.
    send_cmd(12'h007, 5, 2, 510, 3);
    send_words(3, 32'hC0);
    wait_done(3);
    chk("t3_pkt_count", 128'(pkt_count), 128'(3));

    // Empty command.
    bc = beat_cnt;
    send_cmd(12'h009, 1, 3, 0, 0);
    wait_done(4);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_beats", 128'(beat_cnt), 128'(bc));
    chk("t4_pkt_count", 128'(pkt_count), 128'(3));
    chk("t4_done_once", 128'(done_cnt), 128'(4));
    chk("t4_queue_empty", 128'(exp_q.size()), 128'(0));

    // Reset mid-packet after 2 of 4 beats.
    send_cmd(12'h004, 3, 0, 20, 4);
    send_words(2, 32'hD0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    chk("midrst_queue_empty", 128'(exp_q.size()), 128'(0));
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_cmd(12'h004, 3, 0, 20, 2);
    send_words(2, 32'hE0);
    wait_done(d0 + 1);
    chk("t5_pkt_count", 128'(pkt_count), 128'(1));

    // Back-to-back single-beat commands from a fresh reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_cnt;
    send_cmd(12'h011, 6, 2, 100, 1);
    chk("t6_cmd_ready_send", 128'(cmd_ready), 128'(0));
    send_words(1, 32'hF0);
    chk("t6_cmd_ready_drain", 128'(cmd_ready), 128'(0));
    send_cmd(12'h012, 7, 3, 101, 1);
    chk("t6_cmd_ready_send2", 128'(cmd_ready), 128'(0));
    send_words(1, 32'hF1);
    wait_done(d0 + 2);
    chk("t6_done_count", 128'(done_cnt - d0), 128'(2));
    chk("t6_pkt_count", 128'(pkt_count), 128'(2));
    chk("t6_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
